dice_roll_sequencer: RTL



---
 rtl/dice_roll_sequencer_if.sv | 41 ++++
 rtl/dice_roll_sequencer.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/dice_roll_sequencer_if.sv
// Request/roller bundle between game logic, the dice roll sequencer and the roller.
// DICE_SEQ_DROP_LOWEST_EN adds the drop_low request bit.
interface dice_roll_sequencer_if #(
    parameter int TOTAL_W = 9
);
    logic               start;
    logic [2:0]         die_sel;
    logic [3:0]         num_dice;
    logic [4:0]         roll_result;
`ifdef DICE_SEQ_DROP_LOWEST_EN
    logic               drop_low;
`endif
    logic               roll;
    logic [2:0]         die;
    logic               busy;
    logic               done;
    logic [TOTAL_W-1:0] total;
    logic [3:0]         rolls_done;
    logic               range_err;
    logic               sel_err;

`ifdef DICE_SEQ_DROP_LOWEST_EN
    modport master (
        output start, die_sel, num_dice, roll_result, drop_low,
        input  roll, die, busy, done, total, rolls_done, range_err, sel_err
    );
    modport slave (
        input  start, die_sel, num_dice, roll_result, drop_low,
        output roll, die, busy, done, total, rolls_done, range_err, sel_err
    );
`else
    modport master (
        output start, die_sel, num_dice, roll_result,
        input  roll, die, busy, done, total, rolls_done, range_err, sel_err
    );
    modport slave (
        input  start, die_sel, num_dice, roll_result,
        output roll, die, busy, done, total, rolls_done, range_err, sel_err
    );
`endif
endinterface

// File: rtl/dice_roll_sequencer.sv
// Dice roll sequencer: rolls N dice on the external roller and sums the results.
// Optional DICE_SEQ_DROP_LOWEST_EN drops the single lowest roll from the total.
module dice_roll_sequencer #(
    parameter int SETTLE_CYCLES = 1,
    parameter int GAP_CYCLES    = 3,
    parameter int TOTAL_W       = 9
) (
    input logic                   clock,
    input logic                   reset,
    dice_roll_sequencer_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ROLL,
        S_SETTLE,
        S_CAPTURE,
        S_GAP,
        S_DONE
    } state_t;

    state_t             state_q;
    logic [2:0]         die_q;
    logic [3:0]         num_q;
    logic [3:0]         rolls_q;
    logic [3:0]         cnt_q;
    logic [TOTAL_W-1:0] total_q;
    logic               roll_q;
    logic               busy_q;
    logic               done_q;
    logic               rerr_q;
    logic               serr_q;
`ifdef DICE_SEQ_DROP_LOWEST_EN
    logic               drop_q;
    logic [4:0]         min_q;
    logic [4:0]         min_d;
`endif

    logic [4:0]         max_d;
    logic               sel_ok_d;
    logic               out_rng_d;
    logic               last_d;
    logic [TOTAL_W-1:0] sum_d;
    logic [TOTAL_W-1:0] final_d;

    // Capture-cycle helpers: die maximum, range check, running and final sums.
    always_comb begin
        max_d = 5'd0;
        unique case (die_q)
            3'b001:  max_d = 5'd4;
            3'b010:  max_d = 5'd6;
            3'b011:  max_d = 5'd8;
            3'b100:  max_d = 5'd10;
            3'b101:  max_d = 5'd12;
            3'b110:  max_d = 5'd20;
            default: max_d = 5'd0;
        endcase
        sel_ok_d  = (bus.die_sel != 3'b000) && (bus.die_sel != 3'b111);
        out_rng_d = (bus.roll_result == 5'd0) || (bus.roll_result > max_d);
        last_d    = (rolls_q + 4'd1) == num_q;
        sum_d     = total_q + TOTAL_W'(bus.roll_result);
        final_d   = sum_d;
`ifdef DICE_SEQ_DROP_LOWEST_EN
        min_d = (bus.roll_result < min_q) ? bus.roll_result : min_q;
        if (drop_q && (num_q >= 4'd2)) begin
            final_d = sum_d - TOTAL_W'(min_d);
        end
`endif
    end

    // Request FSM with all outputs registered.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            die_q   <= 3'b000;
            num_q   <= 4'd0;
            rolls_q <= 4'd0;
            cnt_q   <= 4'd0;
            total_q <= '0;
            roll_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            rerr_q  <= 1'b0;
            serr_q  <= 1'b0;
`ifdef DICE_SEQ_DROP_LOWEST_EN
            drop_q  <= 1'b0;
            min_q   <= 5'h1f;
`endif
        end else begin
            roll_q <= 1'b0;
            done_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        die_q   <= bus.die_sel;
                        num_q   <= bus.num_dice;
                        total_q <= '0;
                        rolls_q <= 4'd0;
                        rerr_q  <= 1'b0;
                        serr_q  <= 1'b0;
`ifdef DICE_SEQ_DROP_LOWEST_EN
                        drop_q  <= bus.drop_low;
                        min_q   <= 5'h1f;
`endif
                        if (!sel_ok_d) begin
                            serr_q  <= 1'b1;
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end else if (bus.num_dice == 4'd0) begin
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end else begin
                            busy_q  <= 1'b1;
                            roll_q  <= 1'b1;
                            state_q <= S_ROLL;
                        end
                    end
                end
                S_ROLL: begin
                    if (SETTLE_CYCLES > 1) begin
                        cnt_q   <= 4'(SETTLE_CYCLES - 2);
                        state_q <= S_SETTLE;
                    end else begin
                        state_q <= S_CAPTURE;
                    end
                end
                S_SETTLE: begin
                    if (cnt_q == 4'd0) begin
                        state_q <= S_CAPTURE;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                S_CAPTURE: begin
                    rolls_q <= rolls_q + 4'd1;
                    rerr_q  <= rerr_q | out_rng_d;
`ifdef DICE_SEQ_DROP_LOWEST_EN
                    min_q   <= min_d;
`endif
                    if (last_d) begin
                        total_q <= final_d;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        total_q <= sum_d;
                        if (GAP_CYCLES == 0) begin
                            roll_q  <= 1'b1;
                            state_q <= S_ROLL;
                        end else begin
                            cnt_q   <= 4'(GAP_CYCLES - 1);
                            state_q <= S_GAP;
                        end
                    end
                end
                S_GAP: begin
                    if (cnt_q == 4'd0) begin
                        roll_q  <= 1'b1;
                        state_q <= S_ROLL;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.roll       = roll_q;
    assign bus.die        = die_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.total      = total_q;
    assign bus.rolls_done = rolls_q;
    assign bus.range_err  = rerr_q;
    assign bus.sel_err    = serr_q;

endmodule
